// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 2-flop synchronizer, mid-bit sampling, LSB-first framing.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_deser #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int PACK_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_bit,
  output logic                 rx_byte_valid,
  output logic [PACK_SIZE-1:0] rx_byte_data,
  output logic                 rx_active,
  output logic                 rx_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(PACK_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK_SIZE - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx_deser: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef UART_RX_PARITY_EN
    ,
    PARITY
`endif
  } state_t;

  state_t               state, next_state;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [PACK_SIZE-1:0] shreg;
  logic                 cnt_done;
  logic                 stop_good;
  logic                 parity_ok;
  logic                 active_d;
  logic                 valid_d;
  logic                 frame_err_d;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    cnt_done = 1'b0;
    case (state)
      START:   cnt_done = (cnt == CNT_HALF);
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP:    cnt_done = (cnt == CNT_FULL);
      default: cnt_done = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (!rx_s) next_state = START;
      START: if (cnt_done) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (cnt_done && idx == IDX_LAST) next_state = PARITY;
      PARITY: if (cnt_done) next_state = STOP;
`else
      DATA:   if (cnt_done && idx == IDX_LAST) next_state = STOP;
`endif
      STOP:  if (cnt_done) next_state = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          par_q <= 1'b0;
    else if (state == PARITY && cnt_done) par_q <= rx_s;
  end

  assign parity_ok = ~(^{shreg, par_q});
  assign par_err_d = stop_good && !parity_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_parity_err <= 1'b0;
    else        rx_parity_err <= par_err_d;
  end
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    active_d    = (next_state == START) || (next_state == DATA) || (next_state == STOP);
`ifdef UART_RX_PARITY_EN
    active_d    = active_d || (next_state == PARITY);
`endif
    stop_good   = (state == STOP) && cnt_done && rx_s;
    valid_d     = stop_good && parity_ok;
    frame_err_d = (state == STOP) && cnt_done && !rx_s;
  end

  // Bit timer restarts on every state change and after each mid-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (next_state != state || cnt_done || state == IDLE || state == BREAK)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == START)
        idx <= '0;
      else if (state == DATA && cnt_done)
        idx <= idx + 1'b1;
      if (state == DATA && cnt_done)
        shreg <= {rx_s, shreg[PACK_SIZE-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_valid <= 1'b0;
      rx_byte_data  <= '0;
      rx_active     <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_byte_valid <= valid_d;
      rx_frame_err  <= frame_err_d;
      rx_active     <= active_d;
      if (valid_d) rx_byte_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser at 16 clocks per bit.
// Honours UART_RX_PARITY_EN to exercise the parity build as well.
module tb_uart_rx_deser;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_ACTIVE = 8 + 10 * CPB;
`else
  localparam int EXP_ACTIVE = 8 + 9 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_bit = 1'b1;
  logic       rx_byte_valid;
  logic [7:0] rx_byte_data;
  logic       rx_active;
  logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int perr_cnt = 0;
  int both_cnt = 0;
  int active_run = 0;
  int max_active = 0;
  logic [7:0] data_log [0:7];

  uart_rx_deser #(.CLK_FREQ_HZ(1600), .BAUD_RATE(100), .PACK_SIZE(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_bit(rx_bit),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte_data(rx_byte_data),
    .rx_active(rx_active),
    .rx_frame_err(rx_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Pulse and activity monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_byte_valid) begin
        if (valid_cnt < 8) data_log[valid_cnt] = rx_byte_data;
        valid_cnt = valid_cnt + 1;
      end
      if (rx_frame_err) err_cnt = err_cnt + 1;
      if (rx_byte_valid && rx_frame_err) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) perr_cnt = perr_cnt + 1;
`endif
      if (rx_active) active_run = active_run + 1;
      else           active_run = 0;
      if (active_run > max_active) max_active = active_run;
    end
  end

  task automatic clear_monitor();
    valid_cnt  = 0;
    err_cnt    = 0;
    perr_cnt   = 0;
    both_cnt   = 0;
    active_run = 0;
    max_active = 0;
  endtask

  task automatic hold(input logic level, input int cycles);
    rx_bit = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(data[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par_bit, CPB);
`else
    if (par_bit === 1'bx) $display("[TB] note: unknown parity argument");
`endif
    hold(stop_bit, CPB);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_byte_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_byte_valid); end
    n_checks++; if (rx_byte_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 00", rx_byte_data); end
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active: got %b expected 0", rx_active); end
    n_checks++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
    rst_n = 1'b1;
    hold(1'b1, 20);
  endtask

  task automatic test_good_frame();
    clear_monitor();
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 40);
    n_checks++; if (valid_cnt != 1) begin n_fail++; $display("[TB] FAIL good_valid_cycles: got %0d expected 1", valid_cnt); end
    n_checks++; if (data_log[0] !== 8'hA5) begin n_fail++; $display("[TB] FAIL good_data: got %h expected a5", data_log[0]); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("[TB] FAIL good_frame_err: got %0d expected 0", err_cnt); end
    n_checks++; if (max_active != EXP_ACTIVE) begin n_fail++; $display("[TB] FAIL good_active_len: got %0d expected %0d", max_active, EXP_ACTIVE); end
    n_checks++; if (rx_byte_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL good_data_hold: got %h expected a5", rx_byte_data); end
  endtask

  task automatic test_glitch();
    clear_monitor();
    hold(1'b0, 5);
    hold(1'b1, 60);
    n_checks++; if (valid_cnt != 0) begin n_fail++; $display("[TB] FAIL glitch_valid: got %0d expected 0", valid_cnt); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("[TB] FAIL glitch_frame_err: got %0d expected 0", err_cnt); end
    n_checks++; if (max_active != 8) begin n_fail++; $display("[TB] FAIL glitch_active_len: got %0d expected 8", max_active); end
  endtask

  task automatic test_frame_error();
    clear_monitor();
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 200);
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", err_cnt); end
    n_checks++; if (valid_cnt != 0) begin n_fail++; $display("[TB] FAIL ferr_valid: got %0d expected 0", valid_cnt); end
    n_checks++; if (rx_byte_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL ferr_data_kept: got %h expected a5", rx_byte_data); end
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("[TB] FAIL ferr_active_after: got %b expected 0", rx_active); end
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("[TB] FAIL ferr_overlap: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_monitor();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 40);
    n_checks++; if (valid_cnt != 2) begin n_fail++; $display("[TB] FAIL b2b_valid_cycles: got %0d expected 2", valid_cnt); end
    n_checks++; if (data_log[0] !== 8'h00) begin n_fail++; $display("[TB] FAIL b2b_first: got %h expected 00", data_log[0]); end
    n_checks++; if (data_log[1] !== 8'hFF) begin n_fail++; $display("[TB] FAIL b2b_second: got %h expected ff", data_log[1]); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial;
    partial = 8'h81;
    clear_monitor();
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(partial[i], CPB);
    hold(partial[4], CPB / 2);
    rst_n = 1'b0;
    rx_bit = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_active: got %b expected 0", rx_active); end
    n_checks++; if (rx_byte_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_data: got %h expected 00", rx_byte_data); end
    n_checks++; if (rx_byte_valid !== 1'b0 || rx_frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_pulses: got %b%b expected 00", rx_byte_valid, rx_frame_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 40);
    n_checks++; if (valid_cnt != 0 || err_cnt != 0) begin n_fail++; $display("[TB] FAIL midrst_no_pulse: got valid=%0d err=%0d expected 0 0", valid_cnt, err_cnt); end
    send_frame(8'h42, 1'b1, 1'b0);
    hold(1'b1, 40);
    n_checks++; if (valid_cnt != 1) begin n_fail++; $display("[TB] FAIL midrst_valid_cycles: got %0d expected 1", valid_cnt); end
    n_checks++; if (data_log[0] !== 8'h42) begin n_fail++; $display("[TB] FAIL midrst_data_after: got %h expected 42", data_log[0]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_monitor();
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 40);
    n_checks++; if (perr_cnt != 1) begin n_fail++; $display("[TB] FAIL par_bad_pulses: got %0d expected 1", perr_cnt); end
    n_checks++; if (valid_cnt != 0) begin n_fail++; $display("[TB] FAIL par_bad_valid: got %0d expected 0", valid_cnt); end
    n_checks++; if (rx_byte_data !== 8'h42) begin n_fail++; $display("[TB] FAIL par_bad_data_kept: got %h expected 42", rx_byte_data); end
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 40);
    n_checks++; if (valid_cnt != 1) begin n_fail++; $display("[TB] FAIL par_good_valid: got %0d expected 1", valid_cnt); end
    n_checks++; if (data_log[0] !== 8'h07) begin n_fail++; $display("[TB] FAIL par_good_data: got %h expected 07", data_log[0]); end
    n_checks++; if (perr_cnt != 1) begin n_fail++; $display("[TB] FAIL par_good_no_err: got %0d expected 1", perr_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
